// File: rtl/lab4_net_inject_unit.sv
`default_nettype none
// ============================================================================
// Module   : lab4_net_inject_unit
// Brief    : Terminal-side injection stage for the ring router input in2.
//            Stamps {opaque, src, dest}, queues messages in a small FIFO and
//            bounds outstanding messages. Optional counters are enabled by
//            defining LAB4_NET_INJECT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lab4_net_inject_unit #(
    parameter int PAYLOAD_NBITS = 32,
    parameter int NUM_ENTRIES   = 2,
    parameter int MAX_INFLIGHT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               router_id,
    input  logic [1:0]               req_dest,
    input  logic [PAYLOAD_NBITS-1:0] req_payload,
    input  logic                     req_val,
    output logic                     req_rdy,
    output logic [11:0]              out_msg_hdr,
    output logic [PAYLOAD_NBITS-1:0] out_msg_payload,
    output logic                     out_val,
    input  logic                     out_rdy,
    input  logic                     done,
`ifdef LAB4_NET_INJECT_STATS_EN
    output logic [15:0]              inj_count,
    output logic [15:0]              stall_count,
`endif
    output logic [7:0]               inflight
);

    localparam int                c_addr_w       = $clog2(NUM_ENTRIES);
    localparam logic [c_addr_w:0] c_ptr_one      = (c_addr_w+1)'(1);
    localparam logic [7:0]        c_max_inflight = 8'(MAX_INFLIGHT);

    // Header layout: {opaque[7:0], src[1:0], dest[1:0]}
    logic [11:0]              r_mem_hdr     [NUM_ENTRIES];
    logic [PAYLOAD_NBITS-1:0] r_mem_payload [NUM_ENTRIES];
    logic [c_addr_w:0]        r_wr_ptr;
    logic [c_addr_w:0]        r_rd_ptr;
    logic [7:0]               r_opaque;
    logic [7:0]               r_inflight;

    logic w_full;
    logic w_empty;
    logic w_enq;
    logic w_deq;
    logic w_done_eff;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

    assign req_rdy    = !reset && !w_full && (r_inflight < c_max_inflight);
    assign out_val    = !w_empty;
    assign w_enq      = req_val && req_rdy;
    assign w_deq      = out_val && out_rdy;
    assign w_done_eff = done && (r_inflight != 8'd0);

    assign out_msg_hdr     = w_empty ? '0 : r_mem_hdr[r_rd_ptr[c_addr_w-1:0]];
    assign out_msg_payload = w_empty ? '0 : r_mem_payload[r_rd_ptr[c_addr_w-1:0]];
    assign inflight        = r_inflight;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_opaque   <= '0;
            r_inflight <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_mem_hdr[i]     <= '0;
                r_mem_payload[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_mem_hdr[r_wr_ptr[c_addr_w-1:0]]     <= {r_opaque, router_id, req_dest};
                r_mem_payload[r_wr_ptr[c_addr_w-1:0]] <= req_payload;
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                r_opaque <= r_opaque + 8'd1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_enq && !w_done_eff) begin
                r_inflight <= r_inflight + 8'd1;
            end else if (w_done_eff && !w_enq) begin
                r_inflight <= r_inflight - 8'd1;
            end
        end
    end

`ifdef LAB4_NET_INJECT_STATS_EN
    logic [15:0] r_inj_count;
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inj_count   <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_deq && (r_inj_count != 16'hFFFF)) begin
                r_inj_count <= r_inj_count + 16'd1;
            end
            if (req_val && !req_rdy && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign inj_count   = r_inj_count;
    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lab4_net_inject_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab4_net_inject_unit
// Brief    : Self-checking bench: directed vector table, hand-written reset
//            and underflow sequences, and random traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab4_net_inject_unit;

    localparam int c_num_entries  = 2;
    localparam int c_max_inflight = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  router_id;
    logic [1:0]  req_dest;
    logic [31:0] req_payload;
    logic        req_val;
    logic        req_rdy;
    logic [11:0] out_msg_hdr;
    logic [31:0] out_msg_payload;
    logic        out_val;
    logic        out_rdy;
    logic        done;
    logic [7:0]  inflight;
`ifdef LAB4_NET_INJECT_STATS_EN
    logic [15:0] inj_count;
    logic [15:0] stall_count;
`endif

    lab4_net_inject_unit dut (
        .clk             (clk),
        .reset           (reset),
        .router_id       (router_id),
        .req_dest        (req_dest),
        .req_payload     (req_payload),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .out_msg_hdr     (out_msg_hdr),
        .out_msg_payload (out_msg_payload),
        .out_val         (out_val),
        .out_rdy         (out_rdy),
        .done            (done),
`ifdef LAB4_NET_INJECT_STATS_EN
        .inj_count       (inj_count),
        .stall_count     (stall_count),
`endif
        .inflight        (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a message queue plus plain counters.
    typedef struct {
        logic [11:0] hdr;
        logic [31:0] pl;
    } ent_t;
    ent_t q[$];
    int   m_infl;
    int   m_opq;
    int   m_inj;
    int   m_stall;

    task automatic model_clear();
        q.delete();
        m_infl  = 0;
        m_opq   = 0;
        m_inj   = 0;
        m_stall = 0;
    endtask

    // Called at posedge+1; asserts reset between edges and checks it acts at once.
    task automatic do_reset(input string tag);
        req_val = 1'b0;
        done    = 1'b0;
        out_rdy = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk({tag, "_rst_out_val"}, out_val, 1'b0);
        chk({tag, "_rst_inflight"}, inflight, 8'd0);
        chk({tag, "_rst_req_rdy"}, req_rdy, 1'b0);
        chk({tag, "_rst_hdr"}, out_msg_hdr, 12'h000);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
    endtask

    // One model-checked cycle; entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [1:0] d, input logic [31:0] p,
                         input logic ordy, input logic dn, input logic [1:0] rid);
        logic        e_rdy;
        logic        e_oval;
        logic [11:0] e_hdr;
        logic [31:0] e_pl;
        req_val     = v;
        req_dest    = d;
        req_payload = p;
        out_rdy     = ordy;
        done        = dn;
        router_id   = rid;
        #1;
        e_rdy  = (q.size() < c_num_entries) && (m_infl < c_max_inflight);
        e_oval = (q.size() > 0);
        e_hdr  = e_oval ? q[0].hdr : 12'h000;
        e_pl   = e_oval ? q[0].pl : 32'h0;
        chk("rnd_req_rdy", req_rdy, e_rdy);
        chk("rnd_out_val", out_val, e_oval);
        chk("rnd_hdr", out_msg_hdr, e_hdr);
        chk("rnd_payload", out_msg_payload, e_pl);
        chk("rnd_inflight", inflight, 8'(m_infl));
`ifdef LAB4_NET_INJECT_STATS_EN
        chk("rnd_inj_count", inj_count, 16'(m_inj));
        chk("rnd_stall_count", stall_count, 16'(m_stall));
`endif
        @(posedge clk);
        if (e_oval && ordy) begin
            void'(q.pop_front());
            if (m_inj < 65535) m_inj++;
        end
        if (v && !e_rdy && m_stall < 65535) m_stall++;
        if (v && e_rdy) begin
            q.push_back('{hdr: {8'(m_opq), rid, d}, pl: p});
            m_opq = (m_opq + 1) % 256;
        end
        m_infl = m_infl + ((v && e_rdy) ? 1 : 0) - ((dn && m_infl > 0) ? 1 : 0);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  d;
        logic [31:0] p;
        logic        ordy;
        logic        dn;
        logic        e_rdy;
        logic        e_oval;
        logic [11:0] e_hdr;
        logic [31:0] e_pl;
        logic [7:0]  e_infl;
    } vec_t;
    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] rid;
        // Basic injection, full FIFO, inflight limit and enq+done, router_id = 1.
        tbl[0]  = '{1'b1, 2'd3, 32'hCAFE0001, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 32'h0,        8'd0};
        tbl[1]  = '{1'b1, 2'd2, 32'hCAFE0002, 1'b1, 1'b0, 1'b1, 1'b1, 12'h007, 32'hCAFE0001, 8'd1};
        tbl[2]  = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 12'h016, 32'hCAFE0002, 8'd2};
        tbl[3]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 12'h016, 32'hCAFE0002, 8'd1};
        tbl[4]  = '{1'b1, 2'd0, 32'hA0000000, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 32'h0,        8'd0};
        tbl[5]  = '{1'b1, 2'd1, 32'hA1000000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h024, 32'hA0000000, 8'd1};
        tbl[6]  = '{1'b1, 2'd2, 32'hA2000000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h024, 32'hA0000000, 8'd2};
        tbl[7]  = '{1'b1, 2'd2, 32'hA2000000, 1'b1, 1'b0, 1'b0, 1'b1, 12'h024, 32'hA0000000, 8'd2};
        tbl[8]  = '{1'b1, 2'd2, 32'hA2000000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h035, 32'hA1000000, 8'd2};
        tbl[9]  = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 12'h035, 32'hA1000000, 8'd3};
        tbl[10] = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 12'h046, 32'hA2000000, 8'd3};
        tbl[11] = '{1'b1, 2'd3, 32'hB0000000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 32'h0,        8'd3};
        tbl[12] = '{1'b1, 2'd3, 32'hB1000000, 1'b1, 1'b0, 1'b0, 1'b1, 12'h057, 32'hB0000000, 8'd4};
        tbl[13] = '{1'b1, 2'd3, 32'hB1000000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0,        8'd4};
        tbl[14] = '{1'b1, 2'd3, 32'hB1000000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 32'h0,        8'd3};
        tbl[15] = '{1'b0, 2'd0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 12'h067, 32'hB1000000, 8'd4};
        tbl[16] = '{1'b1, 2'd0, 32'hB2000000, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 32'h0,        8'd3};
        tbl[17] = '{1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 12'h074, 32'hB2000000, 8'd3};

        reset       = 1'b0;
        router_id   = 2'd1;
        req_dest    = 2'd0;
        req_payload = 32'h0;
        req_val     = 1'b0;
        out_rdy     = 1'b0;
        done        = 1'b0;
        @(posedge clk);
        #1;
        do_reset("init");

        for (int i = 0; i < 18; i++) begin
            req_val     = tbl[i].v;
            req_dest    = tbl[i].d;
            req_payload = tbl[i].p;
            out_rdy     = tbl[i].ordy;
            done        = tbl[i].dn;
            router_id   = 2'd1;
            #1;
            chk($sformatf("tbl%0d_req_rdy", i), req_rdy, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_out_val", i), out_val, tbl[i].e_oval);
            chk($sformatf("tbl%0d_hdr", i), out_msg_hdr, tbl[i].e_hdr);
            chk($sformatf("tbl%0d_payload", i), out_msg_payload, tbl[i].e_pl);
            chk($sformatf("tbl%0d_inflight", i), inflight, tbl[i].e_infl);
            @(posedge clk);
            #1;
        end

        // Underflow: done with nothing in flight leaves the counter at zero.
        do_reset("uflow");
        cycle(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd1);
        cycle(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 2'd1);
        chk("uflow_inflight", inflight, 8'd0);

        // Mid-stream asynchronous reset with two queued messages.
        cycle(1'b1, 2'd1, 32'h11111111, 1'b0, 1'b0, 2'd2);
        cycle(1'b1, 2'd3, 32'h22222222, 1'b0, 1'b0, 2'd2);
        chk("mid_inflight_before", inflight, 8'd2);
        chk("mid_full_rdy", req_rdy, 1'b0);
        do_reset("mid");
        cycle(1'b1, 2'd0, 32'h33333333, 1'b1, 1'b0, 2'd2);
        chk("mid_first_opaque", out_msg_hdr, {8'h00, 2'd2, 2'd0});
        cycle(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd2);

        // Random traffic: many wraps of the opaque counter, router_id changes.
        do_reset("rnd");
        rid = 2'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) rid = 2'($urandom_range(0, 3));
            cycle($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, rid);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
